usb_line_ctrl: RTL



---
 rtl/usb_line_ctrl_pkg.sv | 22 ++
 rtl/usb_line_ctrl_bit_timer.sv | 48 ++++
 rtl/usb_line_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/usb_line_ctrl_pkg.sv
// Shared constants for the full-speed USB line controller: state encodings,
// default bit timing and the receive error counter width.
package usb_line_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_BUSY   = 3'd1,
        TX_BUSY   = 3'd2,
        WAIT_RESP = 3'd3,
        GAP       = 3'd4
    } line_state_e;

    localparam int CLK_PER_BIT_DEF  = 5;
    localparam int IPG_BITS_DEF     = 2;
    localparam int TIMEOUT_BITS_DEF = 18;
    localparam int CNT_RX           = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_line_ctrl_bit_timer.sv
// Bit-time timer: restarts its tick phase on restart and reports done once
// target bit times have elapsed, holding at terminal without wrapping.
module usb_bit_timer
    import usb_line_ctrl_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
    parameter int BIT_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [BIT_W-1:0] target,
    output logic             done
);

    localparam int PH_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_PER_BIT - 1);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [BIT_W-1:0] bits_q, bits_d;
    logic             bit_tick;

    always_comb begin
        bit_tick = (phase_q == PH_LAST);
        phase_d  = bit_tick ? '0 : phase_q + 1'b1;
        bits_d   = bits_q;
        if (bit_tick && (bits_q != target)) begin
            bits_d = bits_q + 1'b1;
        end
        if (restart) begin
            phase_d = '0;
            bits_d  = '0;
        end
        // Look ahead by one cycle so the FSM leaves exactly on the Nth edge.
        done = (bits_q == target) || (bit_tick && (bits_q == target - 1'b1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
            bits_q  <= '0;
        end else begin
            phase_q <= phase_d;
            bits_q  <= bits_d;
        end
    end

endmodule

// File: rtl/usb_line_ctrl.sv
// Half-duplex D+/D- ownership controller between the packet engines and the
// bit-level PHY. Optional receive error counter: USB_LINE_ERR_CNT_EN.
module usb_line_ctrl
    import usb_line_ctrl_pkg::*;
#(
    parameter int CLK_PER_BIT  = CLK_PER_BIT_DEF,
    parameter int IPG_BITS     = IPG_BITS_DEF,
    parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tx_req,
    input  logic resp_exp,
    input  logic tx_done,
    input  logic rx_start,
    input  logic rx_finish,
    input  logic rx_error,
    output logic tx_gnt,
    output logic tx_en,
    output logic rx_en,
    output logic resp_timeout,
    output logic bus_busy
`ifdef USB_LINE_ERR_CNT_EN
    ,
    input  logic              err_clr,
    output logic [CNT_RX-1:0] err_cnt
`endif
);

    localparam int BIT_W = $clog2(max2(IPG_BITS, TIMEOUT_BITS) + 1);

    line_state_e      state_q, state_d;
    logic             resp_q, resp_d;
    logic             tx_gnt_q, tx_gnt_d;
    logic             tx_en_q, tx_en_d;
    logic             rx_en_q, rx_en_d;
    logic             resp_timeout_q, resp_timeout_d;
    logic             bus_busy_q, bus_busy_d;
    logic             tmr_restart, tmr_done;
    logic [BIT_W-1:0] tmr_target;

    assign tmr_target  = (state_q == GAP) ? BIT_W'(IPG_BITS) : BIT_W'(TIMEOUT_BITS);
    assign tmr_restart = (state_d != state_q);

    usb_bit_timer #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .BIT_W       (BIT_W)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (tmr_restart),
        .target  (tmr_target),
        .done    (tmr_done)
    );

    always_comb begin
        state_d        = state_q;
        resp_d         = resp_q;
        tx_gnt_d       = 1'b0;
        resp_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_start) begin
                    state_d = RX_BUSY;
                end else if (tx_req) begin
                    state_d  = TX_BUSY;
                    tx_gnt_d = 1'b1;
                    resp_d   = resp_exp;
                end
            end
            RX_BUSY: begin
                if (rx_finish || rx_error) begin
                    state_d = GAP;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    state_d = resp_q ? WAIT_RESP : GAP;
                end
            end
            WAIT_RESP: begin
                // A response starting in the expiry cycle beats the timeout.
                if (rx_start) begin
                    state_d = RX_BUSY;
                end else if (tmr_done) begin
                    state_d        = IDLE;
                    resp_timeout_d = 1'b1;
                end
            end
            GAP: begin
                if (rx_start) begin
                    state_d = RX_BUSY;
                end else if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        tx_en_d    = (state_d == TX_BUSY);
        rx_en_d    = (state_d != TX_BUSY);
        bus_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            resp_q         <= 1'b0;
            tx_gnt_q       <= 1'b0;
            tx_en_q        <= 1'b0;
            rx_en_q        <= 1'b0;
            resp_timeout_q <= 1'b0;
            bus_busy_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            resp_q         <= resp_d;
            tx_gnt_q       <= tx_gnt_d;
            tx_en_q        <= tx_en_d;
            rx_en_q        <= rx_en_d;
            resp_timeout_q <= resp_timeout_d;
            bus_busy_q     <= bus_busy_d;
        end
    end

    assign tx_gnt       = tx_gnt_q;
    assign tx_en        = tx_en_q;
    assign rx_en        = rx_en_q;
    assign resp_timeout = resp_timeout_q;
    assign bus_busy     = bus_busy_q;

`ifdef USB_LINE_ERR_CNT_EN
    logic [CNT_RX-1:0] err_cnt_q, err_cnt_d;

    // Counts every rx_error regardless of FSM state; clear wins over a same-cycle error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (rx_error && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
